// File: rtl/ad9851_pkg.sv
// -----------------------------------------------------------------------------
// ad9851_pkg
// Shared definitions for the AD9851 serial loader: the serial word layout,
// the loader state encoding and a helper that assembles the 40-bit word.
// Word layout (bit i is shifted out i-th, LSB first):
//   W0..W31  frequency tuning word
//   W32      6x REFCLK multiplier enable
//   W33      control bit, always 0
//   W34      power-down
//   W35..W39 phase word
// -----------------------------------------------------------------------------
package ad9851_pkg;

    localparam int WORD_W      = 40;
    localparam int W_FTW_LSB   = 0;
    localparam int W_REFMUL    = 32;
    localparam int W_CTRL      = 33;
    localparam int W_PDOWN     = 34;
    localparam int W_PHASE_LSB = 35;

    typedef enum logic [3:0] {
        ST_INIT_RST,
        ST_INIT_WLO,
        ST_INIT_WHI,
        ST_INIT_WEND,
        ST_INIT_FQ,
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_FQUD
    } state_t;

    function automatic logic [WORD_W-1:0] pack_word(
        input logic [31:0] ftw,
        input logic [4:0]  phase,
        input logic        pdown,
        input logic        refmul
    );
        logic [WORD_W-1:0] w;
        w                      = '0;
        w[W_FTW_LSB +: 32]     = ftw;
        w[W_REFMUL]            = refmul;
        w[W_CTRL]              = 1'b0;
        w[W_PDOWN]             = pdown;
        w[W_PHASE_LSB +: 5]    = phase;
        return w;
    endfunction

endpackage

// File: rtl/ad9851_serial_loader_tick_gen.sv
// -----------------------------------------------------------------------------
// ad9851_tick_gen
// Half-period tick generator for the W_CLK timing. o_tick is high during the
// last ACLK cycle of every DIV-cycle half-period. i_restart re-aligns the
// counter so the half-period that follows the restart edge is a full DIV
// cycles long.
// Ports:
//   ACLK       system clock
//   ARESET     asynchronous active-high reset
//   i_restart  start a fresh half-period on this edge
//   o_tick     last cycle of the current half-period
// -----------------------------------------------------------------------------
module ad9851_tick_gen #(
    parameter int DIV = 2
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic i_restart,
    output logic o_tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/ad9851_serial_loader.sv
// -----------------------------------------------------------------------------
// ad9851_serial_loader
// Drives the AD9851 serial interface: after reset it runs the serial-mode
// entry sequence (RESET pulse, one W_CLK pulse, one FQ_UD pulse), then sends
// 40-bit words LSB first on D7 with W_CLK strobes followed by an FQ_UD pulse.
// A one-deep pending register absorbs updates that arrive while busy; a newer
// update overwrites an unsent one and bumps the saturating coalesced count.
// Ports:
//   ACLK, ARESET              clock, asynchronous active-high reset
//   s_ftw/s_phase/s_pdown/s_refmul  word fields
//   s_valid/s_ready           update handshake (ready only after init)
//   dds_reset/dds_wclk/dds_fqud/dds_data  AD9851 pins
//   busy                      init, transfer or pending word outstanding
//   done                      one-cycle pulse as FQ_UD falls after a word
//   coalesced                 saturating count of overwritten pending words
// -----------------------------------------------------------------------------
module ad9851_serial_loader
    import ad9851_pkg::*;
#(
    parameter int DIV          = 2,
    parameter int FQ_UD_CYCLES = 4,
    parameter int RST_CYCLES   = 8
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] s_ftw,
    input  logic [4:0]  s_phase,
    input  logic        s_pdown,
    input  logic        s_refmul,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        dds_reset,
    output logic        dds_wclk,
    output logic        dds_fqud,
    output logic        dds_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] coalesced
);

    localparam int               CNT_W    = 16;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] FQ_LAST  = CNT_W'(FQ_UD_CYCLES - 1);
    localparam logic [5:0]       LAST_BIT = 6'(WORD_W - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [WORD_W-1:0]   r_shift;
    logic [5:0]          r_bit;
    logic                r_pend_valid;
    logic [WORD_W-1:0]   r_pend_word;
    logic [15:0]         r_coalesced;
    logic                r_reset;
    logic                r_wclk;
    logic                r_fqud;
    logic                r_data;
    logic                r_ready;
    logic                r_done;

    logic [WORD_W-1:0]   w_new_word;
    logic [WORD_W-1:0]   w_load_word;
    logic                w_accept;
    logic                w_tick;
    logic                w_rst_last;
    logic                w_fq_last;
    logic                w_start_pend;
    logic                w_start_new;
    logic                w_start;
    logic                w_to_pend;
    logic                w_restart;

    assign w_new_word   = pack_word(s_ftw, s_phase, s_pdown, s_refmul);
    assign w_accept     = s_valid & r_ready;
    assign w_rst_last   = (r_cnt == RST_LAST);
    assign w_fq_last    = (r_cnt == FQ_LAST);

    // A pending word always has priority over a fresh one in IDLE. The
    // FQUD->IDLE edge also starts a fresh word directly, but only when
    // nothing is pending (otherwise the fresh word would overtake it).
    assign w_start_pend = (r_state == ST_IDLE) && r_pend_valid;
    assign w_start_new  = ((r_state == ST_IDLE) || ((r_state == ST_FQUD) && w_fq_last))
                          && !r_pend_valid && w_accept;
    assign w_start      = w_start_pend | w_start_new;
    assign w_to_pend    = w_accept && !w_start_new;
    assign w_load_word  = w_start_pend ? r_pend_word : w_new_word;

    // Realign W_CLK half-periods to the edge that begins a sequence.
    assign w_restart    = ((r_state == ST_INIT_RST) && w_rst_last) || w_start;

    ad9851_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= ST_INIT_RST;
            r_cnt   <= '0;
            r_shift <= '0;
            r_bit   <= '0;
            r_reset <= 1'b1;
            r_wclk  <= 1'b0;
            r_fqud  <= 1'b0;
            r_data  <= 1'b0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_INIT_RST: begin
                    if (w_rst_last) begin
                        r_reset <= 1'b0;
                        r_state <= ST_INIT_WLO;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_INIT_WLO: begin
                    if (w_tick) begin
                        r_wclk  <= 1'b1;
                        r_state <= ST_INIT_WHI;
                    end
                end
                ST_INIT_WHI: begin
                    if (w_tick) begin
                        r_wclk  <= 1'b0;
                        r_state <= ST_INIT_WEND;
                    end
                end
                ST_INIT_WEND: begin
                    if (w_tick) begin
                        r_fqud  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_INIT_FQ;
                    end
                end
                ST_INIT_FQ: begin
                    if (w_fq_last) begin
                        r_fqud  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_tick) begin
                        r_wclk  <= 1'b1;
                        r_state <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    // Data only moves together with the W_CLK falling edge.
                    if (w_tick) begin
                        r_wclk <= 1'b0;
                        if (r_bit == LAST_BIT) begin
                            r_data  <= 1'b0;
                            r_fqud  <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= ST_FQUD;
                        end else begin
                            r_bit   <= r_bit + 6'd1;
                            r_data  <= r_shift[0];
                            r_shift <= {1'b0, r_shift[WORD_W-1:1]};
                            r_state <= ST_SHIFT_LO;
                        end
                    end
                end
                ST_FQUD: begin
                    if (w_fq_last) begin
                        r_fqud  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase

            if (w_start) begin
                r_data  <= w_load_word[0];
                r_shift <= {1'b0, w_load_word[WORD_W-1:1]};
                r_bit   <= '0;
                r_wclk  <= 1'b0;
                r_state <= ST_SHIFT_LO;
            end
        end
    end

    // Pending register and overwrite counter.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_pend_valid <= 1'b0;
            r_pend_word  <= '0;
            r_coalesced  <= '0;
        end else if (w_to_pend) begin
            r_pend_valid <= 1'b1;
            r_pend_word  <= w_new_word;
            // Overwrite only if the old word is not leaving on this edge.
            if (r_pend_valid && !w_start_pend && (r_coalesced != 16'hFFFF)) begin
                r_coalesced <= r_coalesced + 16'd1;
            end
        end else if (w_start_pend) begin
            r_pend_valid <= 1'b0;
        end
    end

    assign s_ready   = r_ready;
    assign dds_reset = r_reset;
    assign dds_wclk  = r_wclk;
    assign dds_fqud  = r_fqud;
    assign dds_data  = r_data;
    assign done      = r_done;
    assign coalesced = r_coalesced;
    assign busy      = (r_state != ST_IDLE) | r_pend_valid;

endmodule

// File: tb/tb_ad9851_serial_loader.sv
// -----------------------------------------------------------------------------
// tb_ad9851_serial_loader
// Timing convention: "rel" is the number of ACLK edges seen since ARESET was
// released (-1 before the first). Outputs sampled on the falling edge after
// edge n belong to spec cycle n+1. A transfer accepted at edge k therefore
// shows bit i for t = n-k in [2*DIV*i, 2*DIV*(i+1)), W_CLK high in the second
// half, FQ_UD for t in [80*DIV, 80*DIV+FQ_UD_CYCLES), done at t=80*DIV+FQ.
// -----------------------------------------------------------------------------
module tb_ad9851_serial_loader;

    localparam int DIV      = 2;
    localparam int FQN      = 4;
    localparam int RSTN     = 8;
    localparam int TX_LEN   = 80 * DIV;
    localparam int END_OFF  = TX_LEN + FQN;
    localparam int INIT_END = RSTN - 1 + 3 * DIV + FQN;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] s_ftw = '0;
    logic [4:0]  s_phase = '0;
    logic        s_pdown = 1'b0;
    logic        s_refmul = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        dds_reset, dds_wclk, dds_fqud, dds_data, busy, done;
    logic [15:0] coalesced;

    ad9851_serial_loader #(
        .DIV          (DIV),
        .FQ_UD_CYCLES (FQN),
        .RST_CYCLES   (RSTN)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .s_ftw     (s_ftw),
        .s_phase   (s_phase),
        .s_pdown   (s_pdown),
        .s_refmul  (s_refmul),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .dds_reset (dds_reset),
        .dds_wclk  (dds_wclk),
        .dds_fqud  (dds_fqud),
        .dds_data  (dds_data),
        .busy      (busy),
        .done      (done),
        .coalesced (coalesced)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          rel = -1;
    bit          tx_act = 0;
    logic [39:0] tx_word;
    int          tx_start = 0;
    bit          pend_v = 0;
    logic [39:0] pend_w;
    int          coal = 0;
    bit          done_exp = 0;
    int          ntx = 0;
    logic [39:0] exp_q[$];
    logic [39:0] got_q[$];

    function automatic logic [39:0] word_of(input logic [31:0] f, input logic [4:0] p,
                                            input logic pd, input logic rm);
        return {p, pd, 1'b0, rm, f};
    endfunction

    task automatic m_start(input logic [39:0] w);
        tx_act   = 1;
        tx_word  = w;
        tx_start = rel;
    endtask

    task automatic m_coal();
        if (coal < 65535) coal++;
    endtask

    initial begin
        forever begin
            @(posedge ACLK);
            if (ARESET) begin
                rel = -1; tx_act = 0; pend_v = 0; coal = 0; done_exp = 0;
            end else begin : model_step
                int          prev;
                bit          acc;
                logic [39:0] w;
                prev     = rel;
                rel      = rel + 1;
                acc      = s_valid && (prev >= INIT_END);
                w        = word_of(s_ftw, s_phase, s_pdown, s_refmul);
                done_exp = 0;
                if (tx_act && rel == tx_start + END_OFF) begin
                    tx_act   = 0;
                    done_exp = 1;
                    exp_q.push_back(tx_word);
                    ntx++;
                    $display("tx %0d sent word %010h done at edge %0d", ntx, tx_word, rel);
                    if (acc) begin
                        if (pend_v) begin m_coal(); pend_w = w; end
                        else m_start(w);
                    end
                end else if (!tx_act) begin
                    if (pend_v) begin
                        m_start(pend_w);
                        pend_v = acc;
                        if (acc) pend_w = w;
                    end else if (acc) begin
                        m_start(w);
                    end
                end else if (acc) begin
                    if (pend_v) m_coal();
                    pend_v = 1;
                    pend_w = w;
                end
            end
        end
    end

    // ---------------- compare + monitors ----------------
    logic        e_rst, e_wclk, e_fq, e_data, e_ready, e_busy, e_done;
    int          e_coal;
    logic        p_wclk = 0, p_data = 0, p_fq = 0;
    logic [39:0] shreg = '0;
    int          nbits = 0, wclk_rises = 0, done_cnt = 0;
    int          last_fq_rise = 0, last_done = 0;
    int          rst_hi = 0, init_wclk_hi = 0, init_fq_hi = 0, init_done = 0, first_ready = -1;

    initial begin
        forever begin
            @(negedge ACLK);
            begin : cmp
                int j, t;
                e_rst = 0; e_wclk = 0; e_fq = 0; e_data = 0; e_ready = 0;
                e_busy = 1; e_done = 0; e_coal = 0;
                if (ARESET) begin
                    e_rst = 1;
                end else if (rel < RSTN - 1) begin
                    e_rst = 1;
                end else if (rel < INIT_END) begin
                    j      = rel - (RSTN - 1);
                    e_wclk = (j >= DIV) && (j < 2 * DIV);
                    e_fq   = (j >= 3 * DIV);
                end else begin
                    e_ready = 1;
                    e_busy  = tx_act || pend_v;
                    e_done  = done_exp;
                    e_coal  = coal;
                    if (tx_act) begin
                        t = rel - tx_start;
                        if (t < TX_LEN) begin
                            e_data = tx_word[t / (2 * DIV)];
                            e_wclk = (t % (2 * DIV)) >= DIV;
                        end else begin
                            e_fq = 1;
                        end
                    end
                end
                check("dds_reset", dds_reset, e_rst);
                check("dds_wclk", dds_wclk, e_wclk);
                check("dds_fqud", dds_fqud, e_fq);
                check("dds_data", dds_data, e_data);
                check("s_ready", s_ready, e_ready);
                check("busy", busy, e_busy);
                check("done", done, e_done);
                check("coalesced", coalesced, e_coal);

                if (ARESET) begin
                    rst_hi = 0; init_wclk_hi = 0; init_fq_hi = 0; init_done = 0;
                    first_ready = -1; nbits = 0;
                end else begin
                    if (rel < INIT_END) begin
                        if (dds_reset) rst_hi++;
                        if (dds_wclk)  init_wclk_hi++;
                        if (dds_fqud)  init_fq_hi++;
                        if (done)      init_done++;
                    end
                    if (s_ready && first_ready < 0) first_ready = rel;
                    if (p_wclk && dds_wclk) check("data_stable_wclk_hi", dds_data, p_data);
                    if (!p_wclk && dds_wclk && rel >= INIT_END) begin
                        shreg = {dds_data, shreg[39:1]};
                        nbits++;
                        wclk_rises++;
                        if (nbits == 40) begin
                            got_q.push_back(shreg);
                            nbits = 0;
                        end
                    end
                    if (!p_fq && dds_fqud && rel >= INIT_END) last_fq_rise = rel;
                    if (done) begin
                        done_cnt++;
                        last_done = rel;
                    end
                end
                p_wclk = dds_wclk; p_data = dds_data; p_fq = dds_fqud;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge ACLK);
        #1;
    endtask

    task automatic send(input logic [31:0] f, input logic [4:0] p, input logic pd, input logic rm);
        s_ftw = f; s_phase = p; s_pdown = pd; s_refmul = rm; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || tx_act || pend_v) && n < 5000) begin
            step();
            n++;
        end
        if (n >= 5000) check("idle_timeout", busy, 0);
        repeat (3) step();
    endtask

    task automatic wait_init();
        int n;
        n = 0;
        while (rel < INIT_END + 2 && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) check("init_timeout", rel, INIT_END + 2);
    endtask

    task automatic check_init(input string tag);
        check({tag, "_reset_cycles"}, rst_hi, 8);
        check({tag, "_wclk_high"}, init_wclk_hi, 2);
        check({tag, "_fqud_high"}, init_fq_hi, 4);
        check({tag, "_done"}, init_done, 0);
        check({tag, "_ready_rel"}, first_ready, 17);
    endtask

    task automatic compare_queues(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check(name, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: actual=running required=finished");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    // ---------------- test sequence ----------------
    initial begin : stim
        int k, kx, ky, n, done_before;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;

        // 1: init sequence
        wait_init();
        check_init("init");

        // 2: single word, timing of FQ_UD and done
        wclk_rises = 0;
        send(32'h0A3D70A4, 5'd0, 1'b0, 1'b1);
        k = rel;
        wait_idle();
        check("t2_model_word", exp_q.size() > 0 ? exp_q[0] : 40'h0, 40'h010A3D70A4);
        check("t2_serial_word", got_q.size() > 0 ? got_q[0] : 40'h0, 40'h010A3D70A4);
        check("t2_wclk_pulses", wclk_rises, 40);
        check("t2_fqud_cycle", last_fq_rise - k + 1, 161);
        check("t2_done_cycle", last_done - k + 1, 165);
        compare_queues("t2_words");

        // 3: coalescing A, B, C
        done_before = done_cnt;
        send(32'h12345678, 5'd3, 1'b0, 1'b0);
        send(32'hCAFEF00D, 5'd7, 1'b1, 1'b0);
        send(32'hDEADBEEF, 5'h10, 1'b0, 1'b1);
        n = 0; k = 0;
        while (done_cnt - done_before < 2 && n < 1000) begin
            if (!busy) k++;
            step();
            n++;
        end
        check("t3_done_pulses", done_cnt - done_before, 2);
        check("t3_busy_low_cycles", k, 0);
        wait_idle();
        check("t3_coalesced", coalesced, 1);
        check("t3_word_a", got_q.size() > 0 ? got_q[0] : 40'h0, 40'h1812345678);
        check("t3_word_c", got_q.size() > 1 ? got_q[1] : 40'h0, 40'h81DEADBEEF);
        compare_queues("t3_words");

        // 4: phase / power-down fields, bit 33 forced low
        send(32'h0, 5'h1F, 1'b1, 1'b0);
        wait_idle();
        check("t4_serial_word", got_q.size() > 0 ? got_q[0] : 40'h0, 40'hFC00000000);
        check("t4_bit33", got_q.size() > 0 ? got_q[0][33] : 1'b1, 1'b0);
        compare_queues("t4_words");

        // accept exactly on the FQUD->IDLE edge
        send(32'h00000001, 5'd1, 1'b0, 1'b0);
        kx = rel;
        n = 0;
        while (rel != kx + END_OFF - 1 && n < 400) begin step(); n++; end
        send(32'h80000000, 5'd2, 1'b0, 1'b1);
        ky = rel;
        wait_idle();
        check("exit_accept_fqud_cycle", last_fq_rise - ky + 1, 161);
        check("exit_accept_words", got_q.size(), 2);
        compare_queues("exit_words");

        // 5: ARESET in the middle of a transfer
        send(32'h55AA55AA, 5'd9, 1'b0, 1'b1);
        n = 0;
        while (nbits < 20 && n < 400) begin step(); n++; end
        check("t5_reached_bit20", nbits, 20);
        done_before = done_cnt;
        ARESET = 1'b1;
        #1;
        check("t5_rst_dds_reset", dds_reset, 1);
        check("t5_rst_wclk", dds_wclk, 0);
        check("t5_rst_fqud", dds_fqud, 0);
        check("t5_rst_data", dds_data, 0);
        check("t5_rst_ready", s_ready, 0);
        check("t5_rst_busy", busy, 1);
        check("t5_rst_done", done, 0);
        check("t5_rst_coalesced", coalesced, 0);
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        wait_init();
        check_init("reinit");
        repeat (200) step();
        check("t5_no_done_aborted", done_cnt - done_before, 0);
        compare_queues("t5_words");

        // random traffic
        for (int it = 0; it < 40; it++) begin
            int gap, burst;
            gap   = $urandom_range(0, 300);
            burst = $urandom_range(1, 3);
            repeat (gap) step();
            for (int b = 0; b < burst; b++)
                send($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end
        wait_idle();
        compare_queues("random_words");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
